// File: rtl/smem_bank_xbar_pkg.sv
// Shared types and constants for the banked shared-memory stage.
// Lane requests are decoded into smem_lane_req_t; read responses are held as smem_lane_rsp_t.
package smem_bank_xbar_pkg;

   localparam int SMEM_NUM_REQS   = 4;
   localparam int SMEM_NUM_BANKS  = 4;
   localparam int SMEM_WORD_SIZE  = 4;
   localparam int SMEM_ADDR_WIDTH = 12;
   localparam int SMEM_TAG_WIDTH  = 8;
   localparam int SMEM_WORD_BITS  = SMEM_WORD_SIZE * 8;

   // A single bank needs no select bits, so the whole address becomes the row.
   function automatic int bank_sel_bits(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 0;
   endfunction

   localparam int SMEM_BANK_SEL_BITS = bank_sel_bits(SMEM_NUM_BANKS);

   typedef struct packed {
      logic                        rw;
      logic [SMEM_ADDR_WIDTH-1:0]  addr;
      logic [SMEM_WORD_SIZE-1:0]   byteen;
      logic [SMEM_WORD_BITS-1:0]   data;
      logic [SMEM_TAG_WIDTH-1:0]   tag;
   } smem_lane_req_t;

   typedef struct packed {
      logic [SMEM_WORD_BITS-1:0]   data;
      logic [SMEM_TAG_WIDTH-1:0]   tag;
   } smem_lane_rsp_t;

endpackage

// File: rtl/smem_bank_xbar_rr_arb.sv
// Round-robin arbiter for one bank: one-hot grant among requesting lanes.
// The search starts at ptr_q; on a grant the pointer moves to the lane after the winner.
module smem_bank_rr_arb #(
   parameter int NUM_REQS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQS-1:0] req,
   output logic [NUM_REQS-1:0] grant
);

   localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic             found;
   int               idx;

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NUM_REQS; off++) begin
         idx = (int'(ptr_q) + off) % NUM_REQS;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            ptr_d      = PTR_W'((idx + 1) % NUM_REQS);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/smem_bank_xbar.sv
// Banked shared-memory stage: per-bank round-robin arbitration over the lane requests,
// single-ported word banks, and one registered read response per lane (1-cycle latency).
module smem_bank_xbar
   import smem_bank_xbar_pkg::*;
#(
   parameter int NUM_REQS  = SMEM_NUM_REQS,
   parameter int NUM_BANKS = SMEM_NUM_BANKS
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_REQS-1:0]                   req_valid,
   input  logic [NUM_REQS-1:0]                   req_rw,
   input  logic [NUM_REQS*SMEM_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQS*SMEM_WORD_SIZE-1:0]    req_byteen,
   input  logic [NUM_REQS*SMEM_WORD_BITS-1:0]    req_data,
   input  logic [NUM_REQS*SMEM_TAG_WIDTH-1:0]    req_tag,
   output logic [NUM_REQS-1:0]                   req_ready,
   output logic [NUM_REQS-1:0]                   rsp_valid,
   output logic [NUM_REQS*SMEM_WORD_BITS-1:0]    rsp_data,
   output logic [NUM_REQS*SMEM_TAG_WIDTH-1:0]    rsp_tag,
   input  logic [NUM_REQS-1:0]                   rsp_ready,
   output logic [31:0]                           perf_bank_stalls
);

   localparam int AW       = SMEM_ADDR_WIDTH;
   localparam int WB       = SMEM_WORD_BITS;
   localparam int SEL_BITS = bank_sel_bits(NUM_BANKS);
   localparam int BANK_W   = (SEL_BITS > 0) ? SEL_BITS : 1;
   localparam int ROW_BITS = AW - SEL_BITS;
   localparam int ROWS     = 1 << ROW_BITS;

   smem_lane_req_t                       lane_req  [NUM_REQS];
   logic [BANK_W-1:0]                    lane_bank [NUM_REQS];
   logic [ROW_BITS-1:0]                  lane_row  [NUM_REQS];
   logic [WB-1:0]                        lane_rdata [NUM_REQS];
   logic [NUM_REQS-1:0]                  eligible;
   logic [NUM_REQS-1:0]                  grant;
   logic [NUM_BANKS-1:0][NUM_REQS-1:0]   bank_gnt;
   logic [NUM_BANKS-1:0][WB-1:0]         bank_rdata;

   logic [NUM_REQS-1:0]                  rsp_valid_q, rsp_valid_d;
   smem_lane_rsp_t [NUM_REQS-1:0]        rsp_q, rsp_d;
   logic [31:0]                          perf_q, perf_d;
   logic                                 stall;

   // A lane with a read response still waiting cannot issue another read;
   // writes never produce a response so they are always eligible.
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         lane_req[i].rw     = req_rw[i];
         lane_req[i].addr   = req_addr[i*AW +: AW];
         lane_req[i].byteen = req_byteen[i*SMEM_WORD_SIZE +: SMEM_WORD_SIZE];
         lane_req[i].data   = req_data[i*WB +: WB];
         lane_req[i].tag    = req_tag[i*SMEM_TAG_WIDTH +: SMEM_TAG_WIDTH];
         lane_bank[i]       = BANK_W'(lane_req[i].addr & AW'(NUM_BANKS - 1));
         lane_row[i]        = ROW_BITS'(lane_req[i].addr >> SEL_BITS);
         eligible[i]        = req_valid[i] && (req_rw[i] || !rsp_valid_q[i] || rsp_ready[i]);
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [NUM_REQS-1:0]       bank_req;
      logic [NUM_REQS-1:0]       gnt;
      logic [ROW_BITS-1:0]       sel_row;
      logic                      sel_we;
      logic [SMEM_WORD_SIZE-1:0] sel_be;
      logic [WB-1:0]             sel_data;
      logic [WB-1:0]             mem_q [ROWS];

      always_comb begin
         for (int i = 0; i < NUM_REQS; i++) begin
            bank_req[i] = eligible[i] && (lane_bank[i] == BANK_W'(b));
         end
      end

      smem_bank_rr_arb #(.NUM_REQS(NUM_REQS)) u_arb (
         .clk   (clk),
         .rst   (reset),
         .req   (bank_req),
         .grant (gnt)
      );

      // The grant is one-hot, so at most one lane drives the bank port.
      always_comb begin
         sel_row  = '0;
         sel_we   = 1'b0;
         sel_be   = '0;
         sel_data = '0;
         for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt[i]) begin
               sel_row  = lane_row[i];
               sel_we   = lane_req[i].rw;
               sel_be   = lane_req[i].byteen;
               sel_data = lane_req[i].data;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (sel_we) begin
            for (int k = 0; k < SMEM_WORD_SIZE; k++) begin
               if (sel_be[k]) begin
                  mem_q[sel_row][k*8 +: 8] <= sel_data[k*8 +: 8];
               end
            end
         end
      end

      assign bank_gnt[b]   = gnt;
      assign bank_rdata[b] = mem_q[sel_row];
   end

   always_comb begin
      grant = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         grant = grant | bank_gnt[b];
      end
   end

   // Responses reload on a new read fire, otherwise hold until consumed.
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         lane_rdata[i] = bank_rdata[lane_bank[i]];
         if (grant[i] && !req_rw[i]) begin
            rsp_valid_d[i]  = 1'b1;
            rsp_d[i].data   = lane_rdata[i];
            rsp_d[i].tag    = lane_req[i].tag;
         end else begin
            rsp_valid_d[i]  = rsp_valid_q[i] && !rsp_ready[i];
            rsp_d[i]        = rsp_q[i];
         end
      end
   end

   always_comb begin
      stall  = |(eligible & ~grant);
      perf_d = perf_q;
      if (stall && (perf_q != '1)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= '0;
         rsp_q       <= '0;
         perf_q      <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         perf_q      <= perf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         rsp_data[i*WB +: WB]                         = rsp_q[i].data;
         rsp_tag[i*SMEM_TAG_WIDTH +: SMEM_TAG_WIDTH]  = rsp_q[i].tag;
      end
   end

   assign req_ready        = grant;
   assign rsp_valid        = rsp_valid_q;
   assign perf_bank_stalls = perf_q;

endmodule

// File: tb/tb_smem_bank_xbar.sv
// Bench for smem_bank_xbar: vector table plus hand sequences, read data checked by a per-lane scoreboard.
module tb_smem_bank_xbar;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [3:0]   req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
   logic [47:0]  req_addr;
   logic [15:0]  req_byteen;
   logic [127:0] req_data, rsp_data;
   logic [31:0]  req_tag, rsp_tag, perf;

   logic [3:0]   req_valid1, req_rw1, req_ready1, rsp_valid1, rsp_ready1;
   logic [47:0]  req_addr1;
   logic [15:0]  req_byteen1;
   logic [127:0] req_data1, rsp_data1;
   logic [31:0]  req_tag1, rsp_tag1, perf1;

   smem_bank_xbar u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
      .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
      .perf_bank_stalls(perf)
   );

   smem_bank_xbar #(.NUM_BANKS(1)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_rw(req_rw1), .req_addr(req_addr1),
      .req_byteen(req_byteen1), .req_data(req_data1), .req_tag(req_tag1), .req_ready(req_ready1),
      .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1), .rsp_ready(rsp_ready1),
      .perf_bank_stalls(perf1)
   );

   typedef struct packed {
      logic [3:0]        valid;
      logic [3:0]        rw;
      logic [3:0][11:0]  addr;
      logic [3:0][3:0]   byteen;
      logic [3:0][31:0]  data;
      logic [3:0][7:0]   tag;
      logic [3:0]        exp_ready;
   } vec_t;

   vec_t         vecs [11];
   vec_t         v;
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [39:0]  exp_q [4][$];
   logic [31:0]  ref_mem [int];
   logic [39:0]  mon_e;

   function automatic vec_t row(input logic [3:0] valid, input logic [3:0] rw, input logic [47:0] addr,
                                input logic [15:0] be, input logic [127:0] data, input logic [31:0] tag,
                                input logic [3:0] rdy);
      return vec_t'({valid, rw, addr, be, data, tag, rdy});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_lane(input int l, input logic vl, input logic rw, input logic [11:0] a,
                           input logic [3:0] be, input logic [31:0] d, input logic [7:0] t);
      req_valid[l] = vl;
      req_rw[l] = rw;
      req_addr[l*12 +: 12] = a;
      req_byteen[l*4 +: 4] = be;
      req_data[l*32 +: 32] = d;
      req_tag[l*8 +: 8] = t;
   endtask

   task automatic set_lane1(input int l, input logic vl, input logic rw, input logic [11:0] a,
                            input logic [31:0] d, input logic [7:0] t);
      req_valid1[l] = vl;
      req_rw1[l] = rw;
      req_addr1[l*12 +: 12] = a;
      req_byteen1[l*4 +: 4] = 4'hF;
      req_data1[l*32 +: 32] = d;
      req_tag1[l*8 +: 8] = t;
   endtask

   // Reference memory: writes apply byte enables, reads queue {tag, data} for that lane.
   task automatic model_fire(input int l, input logic rw, input logic [11:0] a,
                             input logic [3:0] be, input logic [31:0] d, input logic [7:0] t);
      logic [31:0] w;
      w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
      if (rw) begin
         for (int k = 0; k < 4; k++) if (be[k]) w[k*8 +: 8] = d[k*8 +: 8];
         ref_mem[int'(a)] = w;
      end else begin
         exp_q[l].push_back({t, w});
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int l = 0; l < 4; l++) begin
            if (rsp_valid[l] && rsp_ready[l]) begin
               if (exp_q[l].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL rsp_unexpected_l%0d: got tag %0h data %0h expected no response",
                           l, rsp_tag[l*8 +: 8], rsp_data[l*32 +: 32]);
               end else begin
                  mon_e = exp_q[l].pop_front();
                  check($sformatf("rsp_l%0d", l), {rsp_tag[l*8 +: 8], rsp_data[l*32 +: 32]}, mon_e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
      rsp_ready = 4'hF;
      req_valid1 = '0; req_rw1 = '0; req_addr1 = '0; req_byteen1 = '0; req_data1 = '0; req_tag1 = '0;
      rsp_ready1 = 4'hF;

      vecs[0]  = row(4'hF, 4'hF, {12'd3, 12'd2, 12'd1, 12'd0}, 16'hFFFF, {4{32'hDEADBEEF}},
                     {8'h03, 8'h02, 8'h01, 8'h00}, 4'hF);
      vecs[1]  = row(4'hF, 4'h0, {12'd3, 12'd2, 12'd1, 12'd0}, 16'h0, 128'h0,
                     {8'h13, 8'h12, 8'h11, 8'h10}, 4'hF);
      vecs[2]  = row(4'hF, 4'hF, {12'd4, 12'd5, 12'd6, 12'd7}, 16'hFFFF,
                     {32'hA0A00003, 32'hA0A00002, 32'hA0A00001, 32'hA0A00000}, 32'h0, 4'hF);
      vecs[3]  = row(4'hF, 4'h0, {12'd4, 12'd5, 12'd6, 12'd7}, 16'h0, 128'h0,
                     {8'h23, 8'h22, 8'h21, 8'h20}, 4'hF);
      vecs[4]  = row(4'b0011, 4'b0011, {12'd0, 12'd0, 12'd12, 12'd8}, 16'h00FF,
                     {32'h0, 32'h0, 32'hC1C1C1C1, 32'h08080808}, 32'h0, 4'b0001);
      vecs[5]  = row(4'b0011, 4'b0011, {12'd0, 12'd0, 12'd12, 12'd8}, 16'h00FF,
                     {32'h0, 32'h0, 32'h0C0C0C0C, 32'h80808080}, 32'h0, 4'b0010);
      vecs[6]  = row(4'hF, 4'h0, {12'd6, 12'd5, 12'd12, 12'd8}, 16'h0, 128'h0,
                     {8'h33, 8'h32, 8'h31, 8'h30}, 4'b1101);
      vecs[7]  = row(4'b0010, 4'b0010, {12'd0, 12'd0, 12'd5, 12'd0}, 16'h00F0,
                     {32'h0, 32'h0, 32'h11223344, 32'h0}, 32'h0, 4'b0010);
      vecs[8]  = row(4'b0010, 4'b0010, {12'd0, 12'd0, 12'd5, 12'd0}, 16'h0020,
                     {32'h0, 32'h0, 32'h0000AA00, 32'h0}, 32'h0, 4'b0010);
      vecs[9]  = row(4'b0011, 4'h0, {12'd0, 12'd0, 12'd5, 12'd12}, 16'h0, 128'h0,
                     {8'h0, 8'h0, 8'h55, 8'h56}, 4'b0011);
      vecs[10] = row(4'b0001, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd16}, 16'h000F,
                     {32'h0, 32'h0, 32'h0, 32'h16161616}, 32'h0, 4'b0001);

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 4'h0);
      check("reset_rsp_data", rsp_data[63:0] | rsp_data[127:64], 64'h0);
      check("reset_rsp_tag", rsp_tag, 32'h0);
      check("reset_perf", perf, 32'h0);
      check("reset_rsp_valid_1bank", rsp_valid1, 4'h0);
      reset = 1'b0;

      // Vector table: parallel writes/reads, conflicts, byte-enable merge
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         v = vecs[k];
         for (int l = 0; l < 4; l++) set_lane(l, v.valid[l], v.rw[l], v.addr[l], v.byteen[l], v.data[l], v.tag[l]);
         @(negedge clk);
         check($sformatf("vec%0d_ready", k), req_ready, v.exp_ready);
         for (int l = 0; l < 4; l++)
            if (v.exp_ready[l]) model_fire(l, v.rw[l], v.addr[l], v.byteen[l], v.data[l], v.tag[l]);
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("vec_perf_stalls", perf, 32'd3);

      // Four lanes hammering bank 0 after reset: RR order 0,1,2,3 and three stall cycles
      @(negedge clk); #1 reset = 1'b1; #2 reset = 1'b0;
      @(posedge clk); #1;
      for (int l = 0; l < 4; l++) set_lane(l, 1'b1, 1'b0, 12'(4 * (l + 1)), 4'h0, 32'h0, 8'(8'h60 + l));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("conflict_ready_step%0d", k), req_ready, 4'b0001 << k);
         model_fire(k, 1'b0, 12'(4 * (k + 1)), 4'h0, 32'h0, 8'(8'h60 + k));
         @(posedge clk); #1;
         req_valid[k] = 1'b0;
      end
      @(negedge clk);
      check("conflict_perf_stalls", perf, 32'd3);

      // Lane 2 backpressured: response held, next read blocked until rsp_ready rises
      @(posedge clk); #1;
      rsp_ready = 4'b1011;
      set_lane(2, 1'b1, 1'b0, 12'd5, 4'h0, 32'h0, 8'h40);
      @(negedge clk);
      check("hold_first_ready", req_ready, 4'b0100);
      model_fire(2, 1'b0, 12'd5, 4'h0, 32'h0, 8'h40);
      @(posedge clk); #1;
      set_lane(2, 1'b1, 1'b0, 12'd6, 4'h0, 32'h0, 8'h41);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("hold_blocked_c%0d", c), req_ready[2], 1'b0);
         check($sformatf("hold_valid_c%0d", c), rsp_valid[2], 1'b1);
         check($sformatf("hold_data_c%0d", c), {rsp_tag[23:16], rsp_data[95:64]}, {8'h40, 32'h1122AA44});
         @(posedge clk); #1;
      end
      rsp_ready = 4'hF;
      @(negedge clk);
      check("hold_release_ready", req_ready[2], 1'b1);
      model_fire(2, 1'b0, 12'd6, 4'h0, 32'h0, 8'h41);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);

      // Reset with four responses pending; pointers must restart at lane 0
      @(posedge clk); #1;
      rsp_ready = 4'h0;
      for (int l = 0; l < 4; l++) set_lane(l, 1'b1, 1'b0, 12'(4 + l), 4'h0, 32'h0, 8'(8'h50 + l));
      @(negedge clk);
      check("pend_ready", req_ready, 4'hF);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("pend_rsp_valid", rsp_valid, 4'hF);
      #2 reset = 1'b1;
      #1;
      check("async_rst_rsp_valid", rsp_valid, 4'h0);
      check("async_rst_perf", perf, 32'h0);
      check("async_rst_rsp_tag", rsp_tag, 32'h0);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 4'hF;
      set_lane(0, 1'b1, 1'b0, 12'd4, 4'h0, 32'h0, 8'h70);
      set_lane(1, 1'b1, 1'b0, 12'd8, 4'h0, 32'h0, 8'h71);
      @(negedge clk);
      check("post_rst_ptr_lane0", req_ready, 4'b0001);
      model_fire(0, 1'b0, 12'd4, 4'h0, 32'h0, 8'h70);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("post_rst_lane1", req_ready, 4'b0010);
      model_fire(1, 1'b0, 12'd8, 4'h0, 32'h0, 8'h71);
      @(posedge clk); #1;
      req_valid = '0;

      // Single-bank build: concurrent writes and reads are serialized
      set_lane1(0, 1'b1, 1'b1, 12'd3, 32'h33333333, 8'h0);
      set_lane1(1, 1'b1, 1'b1, 12'd9, 32'h99999999, 8'h0);
      @(negedge clk);
      check("b1_wr_ready0", req_ready1, 4'b0001);
      @(posedge clk); #1;
      req_valid1[0] = 1'b0;
      @(negedge clk);
      check("b1_wr_ready1", req_ready1, 4'b0010);
      @(posedge clk); #1;
      set_lane1(0, 1'b1, 1'b0, 12'd9, 32'h0, 8'h80);
      set_lane1(1, 1'b1, 1'b0, 12'd3, 32'h0, 8'h81);
      @(negedge clk);
      check("b1_rd_ready0", req_ready1, 4'b0001);
      @(posedge clk); #1;
      req_valid1[0] = 1'b0;
      @(negedge clk);
      check("b1_rd_ready1", req_ready1, 4'b0010);
      check("b1_rsp_lane0", {rsp_valid1[0], rsp_tag1[7:0], rsp_data1[31:0]}, {1'b1, 8'h80, 32'h99999999});
      @(posedge clk); #1;
      req_valid1 = '0;
      @(negedge clk);
      check("b1_rsp_lane1", {rsp_valid1[1], rsp_tag1[15:8], rsp_data1[63:32]}, {1'b1, 8'h81, 32'h33333333});

      repeat (3) @(negedge clk);
      for (int l = 0; l < 4; l++) check($sformatf("queue_empty_l%0d", l), 64'(exp_q[l].size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
